teclado_atm: RTL and testbench

- Upstream stage of the ATM controller: scans a 4x4 matrix keypad, synchronizes and debounces it, and produces the controller's digit interface (DIGITO / DIGITO_STB).
- Also produces single-cycle ENTER (#) and CANCEL (*) pulses.
- One strobe per physical press, regardless of hold time.

---
 rtl/teclado_atm.sv | 171 +++++++++++++++++
 tb/tb_teclado_atm.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/teclado_atm.sv
// rtl/teclado_atm.sv - 4x4 keypad scanner with synchronizer, debounce and key pulses
// Emits DIGITO/DIGITO_STB, TECLA_ENTER ('#') and TECLA_CANCEL ('*'), one pulse per press.
module teclado_atm #(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] FILAS,
  output logic [3:0] COLUMNAS,
  output logic [3:0] DIGITO,
  output logic       DIGITO_STB,
  output logic       TECLA_ENTER,
  output logic       TECLA_CANCEL
);

  localparam int DW = $clog2(SCAN_CYCLES + 1);
  localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {ESCANEO, REBOTE, EMITIR, ESPERA_SOLTAR} state_t;

  localparam logic [1:0] K_DIGIT  = 2'd0;
  localparam logic [1:0] K_ENTER  = 2'd1;
  localparam logic [1:0] K_CANCEL = 2'd2;
  localparam logic [1:0] K_NONE   = 2'd3;

  state_t      r_state;
  logic [3:0]  r_filas_m;
  logic [3:0]  r_filas_s;
  logic [1:0]  r_col;
  logic [1:0]  r_row;
  logic [3:0]  r_patron;
  logic [DW-1:0] r_dwell;
  logic [BW-1:0] r_deb;
  logic [3:0]  r_digito;
  logic        r_stb;
  logic        r_enter;
  logic        r_cancel;

  logic        w_una_fila;
  logic [1:0]  w_fila_idx;
  logic [5:0]  w_decod;

  always_comb begin
    w_una_fila = 1'b1;
    w_fila_idx = 2'd0;
    case (r_filas_s)
      4'b1110: w_fila_idx = 2'd0;
      4'b1101: w_fila_idx = 2'd1;
      4'b1011: w_fila_idx = 2'd2;
      4'b0111: w_fila_idx = 2'd3;
      default: w_una_fila = 1'b0;
    endcase
  end

  // {kind, value} for the latched row and the held column
  always_comb begin
    w_decod = {K_NONE, 4'd0};
    case ({r_row, r_col})
      4'h0: w_decod = {K_DIGIT, 4'd1};
      4'h1: w_decod = {K_DIGIT, 4'd2};
      4'h2: w_decod = {K_DIGIT, 4'd3};
      4'h4: w_decod = {K_DIGIT, 4'd4};
      4'h5: w_decod = {K_DIGIT, 4'd5};
      4'h6: w_decod = {K_DIGIT, 4'd6};
      4'h8: w_decod = {K_DIGIT, 4'd7};
      4'h9: w_decod = {K_DIGIT, 4'd8};
      4'hA: w_decod = {K_DIGIT, 4'd9};
      4'hC: w_decod = {K_CANCEL, 4'd0};
      4'hD: w_decod = {K_DIGIT, 4'd0};
      4'hE: w_decod = {K_ENTER, 4'd0};
      default: w_decod = {K_NONE, 4'd0};
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_filas_m <= 4'hF;
      r_filas_s <= 4'hF;
    end else begin
      r_filas_m <= FILAS;
      r_filas_s <= r_filas_m;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state  <= ESCANEO;
      r_col    <= 2'd0;
      r_row    <= 2'd0;
      r_patron <= 4'hF;
      r_dwell  <= '0;
      r_deb    <= '0;
      r_digito <= 4'd0;
      r_stb    <= 1'b0;
      r_enter  <= 1'b0;
      r_cancel <= 1'b0;
    end else begin
      r_stb    <= 1'b0;
      r_enter  <= 1'b0;
      r_cancel <= 1'b0;
      case (r_state)
        ESCANEO: begin
          if (r_dwell == DW'(SCAN_CYCLES - 1)) begin
            r_dwell <= '0;
            if (w_una_fila) begin
              r_row    <= w_fila_idx;
              r_patron <= r_filas_s;
              r_deb    <= BW'(1);
              r_state  <= REBOTE;
            end else begin
              r_col <= r_col + 2'd1;
            end
          end else begin
            r_dwell <= r_dwell + DW'(1);
          end
        end
        REBOTE: begin
          if (r_filas_s == r_patron) begin
            if (r_deb >= BW'(DEBOUNCE_CYCLES - 1)) begin
              r_state <= EMITIR;
            end else begin
              r_deb <= r_deb + BW'(1);
            end
          end else begin
            r_col   <= r_col + 2'd1;
            r_dwell <= '0;
            r_deb   <= '0;
            r_state <= ESCANEO;
          end
        end
        EMITIR: begin
          case (w_decod[5:4])
            K_DIGIT: begin
              r_digito <= w_decod[3:0];
              r_stb    <= 1'b1;
            end
            K_ENTER:  r_enter  <= 1'b1;
            K_CANCEL: r_cancel <= 1'b1;
            default: ;
          endcase
          r_deb   <= '0;
          r_state <= ESPERA_SOLTAR;
        end
        ESPERA_SOLTAR: begin
          // release needs DEBOUNCE_CYCLES consecutive all-high samples
          if (r_filas_s == 4'hF) begin
            if (r_deb == BW'(DEBOUNCE_CYCLES - 1)) begin
              r_deb   <= '0;
              r_dwell <= '0;
              r_col   <= r_col + 2'd1;
              r_state <= ESCANEO;
            end else begin
              r_deb <= r_deb + BW'(1);
            end
          end else begin
            r_deb <= '0;
          end
        end
        default: r_state <= ESCANEO;
      endcase
    end
  end

  assign COLUMNAS     = ~(4'b0001 << r_col);
  assign DIGITO       = r_digito;
  assign DIGITO_STB   = r_stb;
  assign TECLA_ENTER  = r_enter;
  assign TECLA_CANCEL = r_cancel;

endmodule

// File: tb/tb_teclado_atm.sv
// tb/tb_teclado_atm.sv - scoreboard bench for teclado_atm with a modelled 4x4 keypad
module tb_teclado_atm;

  logic       Clk;
  logic       Reset;
  logic [3:0] FILAS;
  logic [3:0] COLUMNAS;
  logic [3:0] DIGITO;
  logic       DIGITO_STB;
  logic       TECLA_ENTER;
  logic       TECLA_CANCEL;

  teclado_atm #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(4)) dut (
    .Clk(Clk), .Reset(Reset), .FILAS(FILAS), .COLUMNAS(COLUMNAS),
    .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB),
    .TECLA_ENTER(TECLA_ENTER), .TECLA_CANCEL(TECLA_CANCEL)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // key index = row*4 + col
  logic [15:0] keys;
  always_comb begin
    FILAS = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !COLUMNAS[c]) FILAS[r] = 1'b0;
  end

  typedef struct packed {
    logic [1:0] kind;  // 0 digit, 1 enter, 2 cancel
    logic [3:0] val;   // DIGITO expected in the pulse cycle
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset && (DIGITO_STB || TECLA_ENTER || TECLA_CANCEL)) begin
      exp_t e;
      logic [1:0] k;
      check("pulse_exclusive", 8'(DIGITO_STB + TECLA_ENTER + TECLA_CANCEL), 8'd1);
      k = DIGITO_STB ? 2'd0 : (TECLA_ENTER ? 2'd1 : 2'd2);
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: actual kind=%0d digito=%0d required=no pulse", k, DIGITO);
      end else begin
        e = q.pop_front();
        check("pulse_kind", 8'(k), 8'(e.kind));
        check("pulse_digito", 8'(DIGITO), 8'(e.val));
      end
    end
  end

  task automatic wait_col(input int c);
    logic [3:0] tgt;
    logic [3:0] prev;
    bit ok;
    tgt  = ~(4'b0001 << c);
    prev = COLUMNAS;
    ok   = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge Clk);
      if (COLUMNAS == tgt && prev != tgt) ok = 1;
      prev = COLUMNAS;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_col: actual=%0h required=%0h", COLUMNAS, tgt);
    end
  endtask

  task automatic press(input int idx, input int hold, input int gap);
    wait_col(idx % 4);
    keys[idx] = 1'b1;
    repeat (hold) @(negedge Clk);
    keys[idx] = 1'b0;
    repeat (gap) @(negedge Clk);
  endtask

  task automatic expect_pulse(input logic [1:0] kind, input logic [3:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  logic [3:0] seen;

  initial begin
    keys  = 16'h0;
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_columnas", 8'(COLUMNAS), 8'hE);
    check("rst_digito", 8'(DIGITO), 8'h0);
    check("rst_pulses", 8'({DIGITO_STB, TECLA_ENTER, TECLA_CANCEL}), 8'h0);
    Reset = 1'b1;
    repeat (5) @(negedge Clk);

    // '5' held 40 cycles
    expect_pulse(2'd0, 4'd5);
    press(5, 40, 20);
    check("digito_hold_5", 8'(DIGITO), 8'd5);

    // bouncing '9' gives nothing, then a clean press
    wait_col(2);
    keys[10] = 1'b1; repeat (2) @(negedge Clk);
    keys[10] = 1'b0; repeat (1) @(negedge Clk);
    keys[10] = 1'b1; repeat (2) @(negedge Clk);
    keys[10] = 1'b0; repeat (20) @(negedge Clk);
    check("bounce_no_pulse", 8'(q.size()), 8'd0);
    check("bounce_digito", 8'(DIGITO), 8'd5);
    expect_pulse(2'd0, 4'd9);
    press(10, 20, 20);

    // 6,1,9,5 then '#'
    expect_pulse(2'd0, 4'd6); press(6, 20, 20);
    expect_pulse(2'd0, 4'd1); press(0, 20, 20);
    expect_pulse(2'd0, 4'd9); press(10, 20, 20);
    expect_pulse(2'd0, 4'd5); press(5, 20, 20);
    expect_pulse(2'd1, 4'd5); press(14, 20, 20);
    check("seq_digito", 8'(DIGITO), 8'd5);

    // '*' then 'A'
    expect_pulse(2'd2, 4'd5); press(12, 20, 20);
    press(3, 20, 20);
    seen = 4'h0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      seen = seen | ~COLUMNAS;
    end
    check("scan_resumes", 8'(seen), 8'hF);
    check("after_A_digito", 8'(DIGITO), 8'd5);

    // '1' and '4' together, then release '4'
    wait_col(0);
    keys[0] = 1'b1;
    keys[4] = 1'b1;
    repeat (30) @(negedge Clk);
    check("ghost_no_pulse", 8'(q.size()), 8'd0);
    expect_pulse(2'd0, 4'd1);
    keys[4] = 1'b0;
    repeat (30) @(negedge Clk);
    keys[0] = 1'b0;
    repeat (20) @(negedge Clk);

    // reset while '7' is debouncing
    wait_col(0);
    keys[8] = 1'b1;
    repeat (5) @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("midrst_columnas", 8'(COLUMNAS), 8'hE);
    check("midrst_digito", 8'(DIGITO), 8'h0);
    check("midrst_pulses", 8'({DIGITO_STB, TECLA_ENTER, TECLA_CANCEL}), 8'h0);
    repeat (3) @(negedge Clk);
    expect_pulse(2'd0, 4'd7);
    Reset = 1'b1;
    repeat (30) @(negedge Clk);
    keys[8] = 1'b0;
    repeat (20) @(negedge Clk);
    check("final_digito", 8'(DIGITO), 8'd7);
    check("queue_drained", 8'(q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
